// File: rtl/popcount_seq.sv
// Multi-cycle population count and bit-set classifier: scans one WIDTH-bit word CHUNK bits per clock.
// Optional FIRST_IDX_EN adds first_idx, the index of the lowest set bit of the captured word.
module popcount_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  localparam int N  = WIDTH / CHUNK,
  localparam int CW = $clog2(WIDTH + 1),
  localparam int IW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  input  logic [CW-1:0]    k,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    count,
  output logic             onehot,
  output logic             zero,
  output logic             match,
  output logic [1:0]       dbg_state
`ifdef FIRST_IDX_EN
  ,output logic [IW-1:0]   first_idx
`endif
);

  localparam int IXW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  generate
    if (WIDTH < 2 || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("popcount_seq: WIDTH must be >= 2 and a multiple of CHUNK");
    end
  endgenerate

  // Handshake: start is only looked at in IDLE; busy covers RUN and DONE, and
  // done is a one-cycle pulse marking the result registers as newly valid.
  logic [1:0]       state;
  logic [WIDTH-1:0] shadow;
  logic [CW-1:0]    ktgt;
  logic [CW-1:0]    acc;
  logic [IXW-1:0]   idx;
  logic [CHUNK-1:0] chunk;
  logic [CW-1:0]    chunk_pop;
  logic [CW-1:0]    sum;
  logic             last;

  always_comb begin
    chunk     = shadow[idx*CHUNK +: CHUNK];
    chunk_pop = '0;
    for (int i = 0; i < CHUNK; i++) begin
      chunk_pop = chunk_pop + CW'(chunk[i]);
    end
    sum  = acc + chunk_pop;
    last = (idx == IXW'(N - 1));
  end

`ifdef FIRST_IDX_EN
  logic          found;
  logic [IW-1:0] fi_acc;
  logic [IW-1:0] low_pos;
  logic [IW-1:0] fi_cand;
  logic [IW-1:0] fi_next;

  // Lowest set bit of the current chunk, offset to its position in the word.
  always_comb begin
    low_pos = '0;
    for (int i = CHUNK - 1; i >= 0; i--) begin
      if (chunk[i]) low_pos = IW'(i);
    end
    fi_cand = IW'(int'(idx) * CHUNK) + low_pos;
    fi_next = found ? fi_acc : ((|chunk) ? fi_cand : '0);
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      shadow <= '0;
      ktgt   <= '0;
      acc    <= '0;
      idx    <= '0;
      count  <= '0;
      onehot <= 1'b0;
      zero   <= 1'b0;
      match  <= 1'b0;
`ifdef FIRST_IDX_EN
      found     <= 1'b0;
      fi_acc    <= '0;
      first_idx <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            shadow <= data;
            ktgt   <= k;
            acc    <= '0;
            idx    <= '0;
`ifdef FIRST_IDX_EN
            found  <= 1'b0;
            fi_acc <= '0;
`endif
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          acc <= sum;
          idx <= idx + 1'b1;
`ifdef FIRST_IDX_EN
          if (!found && (|chunk)) begin
            found  <= 1'b1;
            fi_acc <= fi_cand;
          end
`endif
          // The final chunk's sum goes straight to the result registers.
          if (last) begin
            count  <= sum;
            onehot <= (sum == CW'(1));
            zero   <= (sum == '0);
            match  <= (sum == ktgt);
`ifdef FIRST_IDX_EN
            first_idx <= fi_next;
`endif
            state  <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign dbg_state = state;

endmodule
